// File: rtl/sys_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_mem_if
// Purpose  : Memory-side responder on the CPU system bus. Latches an address
//            and write data from SysBus, services word reads/writes to an
//            internal RAM or two memory-mapped I/O registers (switches, LEDs)
//            after a configurable number of wait states, and signals
//            completion with a one-cycle MemRdy pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Clock    in   1   system clock, rising edge
//   nReset   in   1   synchronous active-low reset
//   SysBus   in  16   address (with AdrWe) or write data (with MemWr)
//   AdrWe    in   1   load SysBus into the address register
//   MemRd    in   1   read request
//   MemWr    in   1   write request, data taken from SysBus this cycle
//   Switches in  16   asynchronous switch inputs
//   DataIn   out 16   read data, valid while MemRdy=1, held until next read
//   MemRdy   out  1   access complete, one cycle wide
//   Busy     out  1   an access is outstanding
//   Leds     out 16   LED output register
//   Fault    out  1   sticky error flag, cleared only by reset
// ============================================================================
module sys_mem_if #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] SW_ADDR     = 16'hFFFE,
  parameter logic [15:0] LED_ADDR    = 16'hFFFF
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] SysBus,
  input  logic        AdrWe,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [15:0] Switches,
  output logic [15:0] DataIn,
  output logic        MemRdy,
  output logic        Busy,
  output logic [15:0] Leds,
  output logic        Fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int         RAM_DEPTH = 1 << ADDR_BITS;
  // Counter preload on acceptance; WAIT is skipped entirely when zero.
  localparam logic [3:0] CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        is_wr_q, is_wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_in_q, data_in_d;
  logic        mem_rdy_q, mem_rdy_d;
  logic        busy_q, busy_d;
  logic [15:0] leds_q, leds_d;
  logic        fault_q, fault_d;
  logic [15:0] sw_meta_q, sw_sync_q;

  logic [15:0] mem_q [RAM_DEPTH];

  // Decode is done on the address the current access will use. In IDLE that
  // is addr_d, so an AdrWe in the same cycle as a request takes effect
  // immediately (needed when WAIT_STATES=0 and DONE follows IDLE directly).
  logic        hit_sw, hit_led, hit_ram;
  logic [15:0] rd_val;
  logic        enter_done;

  always_comb begin
    hit_sw  = (addr_d == SW_ADDR);
    hit_led = (addr_d == LED_ADDR);
    hit_ram = ((addr_d >> ADDR_BITS) == 16'd0);
    if (hit_sw)       rd_val = sw_sync_q;
    else if (hit_led) rd_val = leds_q;
    else if (hit_ram) rd_val = mem_q[addr_d[ADDR_BITS-1:0]];
    else              rd_val = 16'h0000;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    leds_d    = leds_q;
    fault_d   = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (AdrWe) addr_d = SysBus;
        if (MemRd ^ MemWr) begin
          is_wr_d = MemWr;
          if (MemWr) wr_data_d = SysBus;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_DONE;
          end
        end else if (MemRd && MemWr) begin
          fault_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (is_wr_q && hit_led && !hit_sw) leds_d = wr_data_q;
      end
      default: state_d = ST_IDLE;
    endcase

    enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Read data and decode errors are resolved on the edge entering DONE so
    // that DataIn and Fault are already valid during the MemRdy cycle.
    data_in_d = data_in_q;
    if (enter_done) begin
      if (!is_wr_d) begin
        data_in_d = rd_val;
        if (!(hit_sw || hit_led || hit_ram)) fault_d = 1'b1;
      end else if (hit_sw || !(hit_led || hit_ram)) begin
        fault_d = 1'b1;
      end
    end

    mem_rdy_d = enter_done;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      addr_q    <= 16'h0000;
      wr_data_q <= 16'h0000;
      is_wr_q   <= 1'b0;
      cnt_q     <= 4'd0;
      data_in_q <= 16'h0000;
      mem_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      leds_q    <= 16'h0000;
      fault_q   <= 1'b0;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      data_in_q <= data_in_d;
      mem_rdy_q <= mem_rdy_d;
      busy_q    <= busy_d;
      leds_q    <= leds_d;
      fault_q   <= fault_d;
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM is not reset; the write commits on the edge leaving DONE, so a reset
  // asserted during WAIT or DONE suppresses it.
  always_ff @(posedge Clock) begin
    if (nReset && (state_q == ST_DONE) && is_wr_q && hit_ram && !hit_sw && !hit_led) begin
      mem_q[addr_q[ADDR_BITS-1:0]] <= wr_data_q;
    end
  end

  assign DataIn = data_in_q;
  assign MemRdy = mem_rdy_q;
  assign Busy   = busy_q;
  assign Leds   = leds_q;
  assign Fault  = fault_q;

endmodule
`default_nettype wire
